cache_performance_reader: RTL and testbench
===========================================

# cache_performance_reader

Host-side sequencer for the cache performance monitor's config/data register pair. It drives the monitor's control word (counting enable in bit 24, readout select in bits 4:0), waits out the monitor's registered readout latency, and assembles each 64-bit counter from its two 32-bit halves. It emits the six metrics on a valid/ready stream and captures the cache structure/replacement ID word. It sits between the monitor and the CPU-side peripheral bus.

## Interface
Parameters:
- BW_CONFIG_REGS, 32, width of the monitor control/data words (≥25)
- SETTLE_CYCLES, 2, cycles from a select change to a valid data_i sample (≥2)
- HOLD_DURING_READ, 1, 1 = clear counting enable for the whole readout (coherent snapshot)

Ports:
- clock_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  software request for counting enabled
- start_i  in  1  single-cycle readout request
- data_i  in  BW_CONFIG_REGS  monitor data0_o
- config_o  out  BW_CONFIG_REGS  to monitor config0_i: bit 24 = enable, bits 4:0 = select, all others 0
- busy_o  out  1  readout in progress
- done_o  out  1  one-cycle pulse at the end of a readout
- metric_valid_o  out  1  stream valid
- metric_ready_i  in  1  stream ready
- metric_id_o  out  3  0 cycle, 1 hit, 2 miss, 3 writeback, 4 expired, 5 default
- metric_data_o  out  64  {hi, lo} counter value
- cache_id_o  out  BW_CONFIG_REGS  ID word captured from select 0x0F

## Operation
- States: IDLE, SEL_LO, WAIT_LO, SEL_HI, WAIT_HI, EMIT, SEL_ID, WAIT_ID, DONE.
- IDLE: config_o[24] = enable_i (registered) and select = 0. Sampling start_i=1 goes to SEL_LO with metric index k=0. busy_o is set in the same edge.
- SEL_x: register select (lo = 2k, hi = 2k+1, id = 0x0F) into config_o and load the settle counter with SETTLE_CYCLES-1.
- WAIT_x: decrement the settle counter. At zero, capture data_i:
  - lo → metric_data_o[31:0], then SEL_HI.
  - hi → metric_data_o[63:32], then EMIT.
  - id → cache_id_o, then DONE.
- EMIT: metric_valid_o=1 and metric_id_o=k. The metric transfers on valid&&ready. Then k<5: k+1 → SEL_LO; k=5 → SEL_ID.
- EMIT holds metric_data_o and metric_id_o stable while valid is high and ready is low. Backpressure is unbounded.
- DONE: done_o=1 for one cycle, busy_o cleared, select returns to 0. Next state is IDLE.
- HOLD_DURING_READ=1: config_o[24]=0 from the SEL_LO entry edge until DONE. In DONE, config_o[24] is restored from enable_i. hi/lo and all metrics come from one frozen snapshot.
- HOLD_DURING_READ=0: config_o[24] tracks enable_i throughout. hi/lo tearing is possible and is not corrected.
- start_i while busy_o=1 is ignored, with no queueing.
- enable_i changes while busy are applied in DONE (HOLD=1), or on the next edge (HOLD=0).
- The select counter for 2k+1 never exceeds 0x0B. Codes 0x0C–0x0E are never issued.

## Timing
- Reset: config_o=0, busy_o=0, done_o=0, metric_valid_o=0, metric_id_o=0, metric_data_o=0, cache_id_o=0, state IDLE, k=0.
- Reset asserted mid-readout aborts immediately to the reset values. No done_o pulse is produced.
- The monitor registers its readout one edge after seeing a select. The reader samples data_i exactly SETTLE_CYCLES edges after the edge that changed config_o.
- Per half: 1 SEL cycle + SETTLE_CYCLES WAIT cycles.
- With ready tied high and SETTLE=2, the start-to-done_o latency is 6·(2·3+1)+3+1 = 46 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the select codes (CYCLE_LO=0x00 … DEFAULT_HI=0x0B, CACHE_ID=0x0F)
  - the enable bit index 24 and the select field [4:0]
  - the metric-ID enum
  - the state enum
- Single module; the settle counter and FSM are small enough that no sub-module is warranted.

## Test plan
- Monitor model with counters cycle=0x1_0000_0005, hit=7, others 0. Pulse start with ready=1. Required: six beats, ids 0..5 in order; id0 data=0x0000_0001_0000_0005, id1=7; done_o pulses 46 cycles after start.
- HOLD=1, enable_i=1, flags_i[0] asserted every cycle during readout. Required: config_o[24]=0 throughout busy; the hit value equals its value at start; bit 24 returns to 1 in DONE.
- Backpressure: ready low for 10 cycles on id 2. Required: valid held high, data/id stable, no further select change until the handshake completes.
- Readout completes with the ID word set to 0x0000_0102 in the model. Required: cache_id_o=0x0000_0102 at done_o.
- Second start pulse during busy. Required: exactly one done_o and six beats.
- Assert resetn_i low in WAIT_HI of id 3. Required: all outputs at reset values asynchronously, no done_o; a subsequent start runs a full, correct readout.

Source files
------------

// File: rtl/cache_performance_reader_pkg.sv
// rtl/cache_performance_reader_pkg.sv - select codes, field positions and enums for the monitor readout sequencer
package cache_performance_reader_pkg;

    localparam int SEL_W      = 5;
    localparam int SEL_MSB    = 4;
    localparam int SEL_LSB    = 0;
    localparam int ENABLE_BIT = 24;

    localparam logic [SEL_W-1:0] SEL_CYCLE_LO     = 5'h00;
    localparam logic [SEL_W-1:0] SEL_CYCLE_HI     = 5'h01;
    localparam logic [SEL_W-1:0] SEL_HIT_LO       = 5'h02;
    localparam logic [SEL_W-1:0] SEL_HIT_HI       = 5'h03;
    localparam logic [SEL_W-1:0] SEL_MISS_LO      = 5'h04;
    localparam logic [SEL_W-1:0] SEL_MISS_HI      = 5'h05;
    localparam logic [SEL_W-1:0] SEL_WRITEBACK_LO = 5'h06;
    localparam logic [SEL_W-1:0] SEL_WRITEBACK_HI = 5'h07;
    localparam logic [SEL_W-1:0] SEL_EXPIRED_LO   = 5'h08;
    localparam logic [SEL_W-1:0] SEL_EXPIRED_HI   = 5'h09;
    localparam logic [SEL_W-1:0] SEL_DEFAULT_LO   = 5'h0A;
    localparam logic [SEL_W-1:0] SEL_DEFAULT_HI   = 5'h0B;
    localparam logic [SEL_W-1:0] SEL_CACHE_ID     = 5'h0F;

    typedef enum logic [2:0] {
        MID_CYCLE     = 3'd0,
        MID_HIT       = 3'd1,
        MID_MISS      = 3'd2,
        MID_WRITEBACK = 3'd3,
        MID_EXPIRED   = 3'd4,
        MID_DEFAULT   = 3'd5
    } metric_id_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL_LO,
        ST_WAIT_LO,
        ST_SEL_HI,
        ST_WAIT_HI,
        ST_EMIT,
        ST_SEL_ID,
        ST_WAIT_ID,
        ST_DONE
    } state_e;

    // Counter halves are laid out as lo = 2k, hi = 2k+1, so the top code is DEFAULT_HI.
    function automatic logic [SEL_W-1:0] counter_select(input metric_id_e k, input logic hi);
        return {1'b0, k, hi};
    endfunction

endpackage

// File: rtl/cache_performance_reader.sv
// rtl/cache_performance_reader.sv - sequences the monitor select/data pair and streams six 64-bit counters
module cache_performance_reader
    import cache_performance_reader_pkg::*;
#(
    parameter int BW_CONFIG_REGS   = 32,
    parameter int SETTLE_CYCLES    = 2,
    parameter bit HOLD_DURING_READ = 1'b1
) (
    input  logic                      clock_i,
    input  logic                      resetn_i,
    input  logic                      enable_i,
    input  logic                      start_i,
    input  logic [BW_CONFIG_REGS-1:0] data_i,
    output logic [BW_CONFIG_REGS-1:0] config_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      metric_valid_o,
    input  logic                      metric_ready_i,
    output logic [2:0]                metric_id_o,
    output logic [63:0]               metric_data_o,
    output logic [BW_CONFIG_REGS-1:0] cache_id_o
);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state;
    metric_id_e       k;
    logic [CNT_W-1:0] settle_cnt;
    logic             count_en;
    logic [SEL_W-1:0] sel;
    logic             settled;

    assign settled = (settle_cnt == '0);

    always_comb begin
        config_o                  = '0;
        config_o[ENABLE_BIT]      = count_en;
        config_o[SEL_MSB:SEL_LSB] = sel;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state          <= ST_IDLE;
            k              <= MID_CYCLE;
            settle_cnt     <= '0;
            count_en       <= 1'b0;
            sel            <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            metric_valid_o <= 1'b0;
            metric_id_o    <= '0;
            metric_data_o  <= '0;
            cache_id_o     <= '0;
        end else begin
            done_o <= 1'b0;
            // A held readout keeps the monitor frozen so hi/lo and all six metrics share one snapshot.
            if (!HOLD_DURING_READ || !busy_o) begin
                count_en <= enable_i;
            end
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_SEL_LO;
                        k      <= MID_CYCLE;
                        busy_o <= 1'b1;
                        if (HOLD_DURING_READ) begin
                            count_en <= 1'b0;
                        end
                    end
                end
                ST_SEL_LO: begin
                    sel        <= counter_select(k, 1'b0);
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (settled) begin
                        metric_data_o[31:0] <= 32'(data_i);
                        state               <= ST_SEL_HI;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_SEL_HI: begin
                    sel        <= counter_select(k, 1'b1);
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (settled) begin
                        metric_data_o[63:32] <= 32'(data_i);
                        metric_valid_o       <= 1'b1;
                        metric_id_o          <= k;
                        state                <= ST_EMIT;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (metric_ready_i) begin
                        metric_valid_o <= 1'b0;
                        if (k == MID_DEFAULT) begin
                            state <= ST_SEL_ID;
                        end else begin
                            k     <= metric_id_e'(k + 3'd1);
                            state <= ST_SEL_LO;
                        end
                    end
                end
                ST_SEL_ID: begin
                    sel        <= SEL_CACHE_ID;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_WAIT_ID;
                end
                ST_WAIT_ID: begin
                    if (settled) begin
                        cache_id_o <= data_i;
                        sel        <= '0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        count_en   <= enable_i;
                        state      <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_performance_reader.sv
// tb/tb_cache_performance_reader.sv - randomized bench with a counting monitor model and readout scoreboard
module tb_cache_performance_reader;

    logic        clk;
    logic        resetn_i;
    logic        enable_i;
    logic        start_i;
    logic [31:0] data_i;
    logic [31:0] config_o;
    logic        busy_o;
    logic        done_o;
    logic        metric_valid_o;
    logic        metric_ready_i;
    logic [2:0]  metric_id_o;
    logic [63:0] metric_data_o;
    logic [31:0] cache_id_o;

    cache_performance_reader dut (
        .clock_i        (clk),
        .resetn_i       (resetn_i),
        .enable_i       (enable_i),
        .start_i        (start_i),
        .data_i         (data_i),
        .config_o       (config_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .metric_valid_o (metric_valid_o),
        .metric_ready_i (metric_ready_i),
        .metric_id_o    (metric_id_o),
        .metric_data_o  (metric_data_o),
        .cache_id_o     (cache_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor stand-in: six 64-bit counters, cycle/hit count while bit 24 is set, registered readout.
    logic [63:0] mon_base [6];
    logic [31:0] mon_id_word;
    logic [63:0] inc_cycle;
    logic [63:0] inc_hit;
    logic        mon_clr;
    logic        hit_flag;
    logic [63:0] mon_tmp;
    logic [4:0]  mon_sel;

    function automatic logic [63:0] mon_counter(input int idx);
        logic [63:0] v;
        v = mon_base[idx];
        if (idx == 0) v = v + inc_cycle;
        if (idx == 1) v = v + inc_hit;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mon_clr) begin
            inc_cycle <= 64'd0;
            inc_hit   <= 64'd0;
        end else if (config_o[24]) begin
            inc_cycle <= inc_cycle + 64'd1;
            if (hit_flag) inc_hit <= inc_hit + 64'd1;
        end
        mon_sel = config_o[4:0];
        if (mon_sel == 5'h0F) begin
            data_i <= mon_id_word;
        end else if (mon_sel < 5'd12) begin
            mon_tmp = mon_counter(int'(mon_sel[4:1]));
            data_i <= mon_sel[0] ? mon_tmp[63:32] : mon_tmp[31:0];
        end else begin
            data_i <= 32'hDEAD_BEEF;
        end
    end

    // Observations gathered by do_readout.
    logic [2:0]  got_id [$];
    logic [63:0] got_data [$];
    logic [63:0] snap [6];
    int          latency;
    int          done_cnt;
    int          hold_viol;
    int          bad_sel;
    logic [31:0] cid_at_done;
    logic        en_at_done;

    task automatic randomize_monitor();
        for (int i = 0; i < 6; i++) mon_base[i] = {$urandom, $urandom};
        mon_id_word = $urandom;
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic do_readout(input int ready_pct, input bit second_start);
        got_id.delete();
        got_data.delete();
        latency   = -1;
        done_cnt  = 0;
        hold_viol = 0;
        bad_sel   = 0;
        @(negedge clk);
        start_i        = 1'b1;
        metric_ready_i = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            start_i = second_start && (cyc == 5);
            if (cyc == 1) for (int i = 0; i < 6; i++) snap[i] = mon_counter(i);
            if (busy_o && config_o[24]) hold_viol++;
            if (config_o[4:0] inside {[5'h0C:5'h0E]} || config_o[4:0] > 5'h0F) bad_sel++;
            if (done_o) begin
                done_cnt++;
                if (latency < 0) begin
                    latency     = cyc;
                    cid_at_done = cache_id_o;
                    en_at_done  = config_o[24];
                end
            end
            if (latency >= 0 && cyc >= latency + 4) break;
            metric_ready_i = ($urandom_range(0, 99) < ready_pct);
            if (metric_valid_o && metric_ready_i) begin
                got_id.push_back(metric_id_o);
                got_data.push_back(metric_data_o);
            end
        end
        start_i        = 1'b0;
        metric_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        resetn_i = 1'b0; enable_i = 1'b0; start_i = 1'b0; metric_ready_i = 1'b1;
        mon_clr = 1'b1; hit_flag = 1'b0; mon_id_word = 32'd0;
        for (int i = 0; i < 6; i++) mon_base[i] = 64'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (config_o !== 32'd0) begin n_fail++; $display("FAIL reset_config: got %h expected %h", config_o, 32'd0); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_cmp++; if (metric_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", metric_valid_o); end
        n_cmp++; if (metric_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", metric_id_o); end
        n_cmp++; if (metric_data_o !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", metric_data_o); end
        n_cmp++; if (cache_id_o !== 32'd0) begin n_fail++; $display("FAIL reset_cache_id: got %h expected 0", cache_id_o); end
        resetn_i = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] exp_data [6];
        enable_i = 1'b0;
        exp_data = '{64'h0000_0001_0000_0005, 64'd7, 64'd0, 64'd0, 64'd0, 64'd0};
        for (int i = 0; i < 6; i++) mon_base[i] = exp_data[i];
        mon_id_word = 32'h0000_0102;
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        do_readout(100, 1'b0);
        n_cmp++; if (latency !== 46) begin n_fail++; $display("FAIL basic_latency: got %0d expected 46", latency); end
        n_cmp++; if (got_id.size() !== 6) begin n_fail++; $display("FAIL basic_beats: got %0d expected 6", got_id.size()); end
        for (int i = 0; i < got_id.size() && i < 6; i++) begin
            n_cmp++; if (got_id[i] !== 3'(i)) begin n_fail++; $display("FAIL basic_id[%0d]: got %0d expected %0d", i, got_id[i], i); end
            n_cmp++; if (got_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); end
        end
        n_cmp++; if (cid_at_done !== 32'h0000_0102) begin n_fail++; $display("FAIL basic_cache_id: got %h expected 00000102", cid_at_done); end
        n_cmp++; if (bad_sel !== 0) begin n_fail++; $display("FAIL basic_select_range: got %0d bad cycles expected 0", bad_sel); end
    endtask

    task automatic test_hold();
        randomize_monitor();
        enable_i = 1'b1;
        hit_flag = 1'b1;
        repeat (20) @(negedge clk);
        do_readout(100, 1'b0);
        n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL hold_enable_low: got %0d busy cycles with bit24 set expected 0", hold_viol); end
        n_cmp++; if (en_at_done !== 1'b1) begin n_fail++; $display("FAIL hold_enable_restored: got %b expected 1", en_at_done); end
        n_cmp++; if (got_data.size() !== 6) begin n_fail++; $display("FAIL hold_beats: got %0d expected 6", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            n_cmp++; if (got_data[i] !== snap[i]) begin n_fail++; $display("FAIL hold_snapshot[%0d]: got %h expected %h", i, got_data[i], snap[i]); end
        end
        hit_flag = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int          stall;
        int          beats;
        bit          finished;
        logic [63:0] held_data;
        logic [4:0]  held_sel;
        randomize_monitor();
        stall = 0; beats = 0; finished = 1'b0;
        @(negedge clk);
        start_i = 1'b1; metric_ready_i = 1'b1;
        for (int cyc = 1; cyc <= 500; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (cyc == 1) for (int i = 0; i < 6; i++) snap[i] = mon_counter(i);
            if (done_o) begin finished = 1'b1; break; end
            if (metric_valid_o && metric_id_o == 3'd2 && stall < 10) begin
                if (stall == 0) begin
                    held_data = metric_data_o;
                    held_sel  = config_o[4:0];
                end else begin
                    n_cmp++; if (metric_data_o !== held_data) begin n_fail++; $display("FAIL bp_data_stable: got %h expected %h", metric_data_o, held_data); end
                    n_cmp++; if (config_o[4:0] !== held_sel) begin n_fail++; $display("FAIL bp_select_stable: got %h expected %h", config_o[4:0], held_sel); end
                end
                stall++;
                metric_ready_i = 1'b0;
            end else begin
                if (stall > 0 && stall < 10) begin
                    n_cmp++; n_fail++;
                    $display("FAIL bp_valid_held: got valid=%b id=%0d expected valid=1 id=2", metric_valid_o, metric_id_o);
                    stall = 10;
                end
                metric_ready_i = 1'b1;
                if (metric_valid_o) begin
                    beats++;
                    n_cmp++; if (metric_data_o !== snap[metric_id_o]) begin n_fail++; $display("FAIL bp_beat_data[%0d]: got %h expected %h", metric_id_o, metric_data_o, snap[metric_id_o]); end
                end
            end
        end
        metric_ready_i = 1'b1;
        n_cmp++; if (stall !== 10) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 10", stall); end
        n_cmp++; if (beats !== 6) begin n_fail++; $display("FAIL bp_beats: got %0d expected 6", beats); end
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", finished); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_second_start();
        randomize_monitor();
        do_readout(100, 1'b1);
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL dup_start_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (got_id.size() !== 6) begin n_fail++; $display("FAIL dup_start_beats: got %0d expected 6", got_id.size()); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dup_start_idle_after: got busy=%b expected 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        bit found;
        randomize_monitor();
        found = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (config_o[4:0] == 5'h07) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_wait_hi3: got %b expected 1", found); end
        resetn_i = 1'b0;
        #1;
        n_cmp++; if (config_o !== 32'd0) begin n_fail++; $display("FAIL midreset_config: got %h expected 0", config_o); end
        n_cmp++; if (busy_o !== 1'b0 || metric_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_valid: got %b%b expected 00", busy_o, metric_valid_o); end
        n_cmp++; if (metric_data_o !== 64'd0 || metric_id_o !== 3'd0 || cache_id_o !== 32'd0) begin n_fail++; $display("FAIL midreset_data: got %h/%0d/%h expected 0/0/0", metric_data_o, metric_id_o, cache_id_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b expected 0", done_o); end
        end
        resetn_i = 1'b1;
        @(negedge clk);
        randomize_monitor();
        do_readout(70, 1'b0);
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL midreset_rerun_done: got %0d expected 1", done_cnt); end
        n_cmp++; if (got_id.size() !== 6) begin n_fail++; $display("FAIL midreset_rerun_beats: got %0d expected 6", got_id.size()); end
        for (int i = 0; i < got_id.size() && i < 6; i++) begin
            n_cmp++; if (got_id[i] !== 3'(i) || got_data[i] !== snap[i]) begin n_fail++; $display("FAIL midreset_rerun_beat[%0d]: got id %0d data %h expected id %0d data %h", i, got_id[i], got_data[i], i, snap[i]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            randomize_monitor();
            enable_i = $urandom_range(0, 1);
            hit_flag = $urandom_range(0, 1);
            repeat ($urandom_range(1, 8)) @(negedge clk);
            do_readout(30 + 20 * it, 1'b0);
            n_cmp++; if (latency < 46) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected at least 46", it, latency); end
            n_cmp++; if (got_id.size() !== 6) begin n_fail++; $display("FAIL rand%0d_beats: got %0d expected 6", it, got_id.size()); end
            for (int i = 0; i < got_id.size() && i < 6; i++) begin
                n_cmp++; if (got_id[i] !== 3'(i) || got_data[i] !== snap[i]) begin n_fail++; $display("FAIL rand%0d_beat[%0d]: got id %0d data %h expected id %0d data %h", it, i, got_id[i], got_data[i], i, snap[i]); end
            end
            n_cmp++; if (cid_at_done !== mon_id_word) begin n_fail++; $display("FAIL rand%0d_cache_id: got %h expected %h", it, cid_at_done, mon_id_word); end
            n_cmp++; if (hold_viol !== 0 || en_at_done !== enable_i) begin n_fail++; $display("FAIL rand%0d_enable: got viol %0d done-bit %b expected 0 and %b", it, hold_viol, en_at_done, enable_i); end
        end
        enable_i = 1'b0;
        hit_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_backpressure();
        test_second_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
